// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer and its SoC neighbours.
//   SimState      : simulation-control state used elsewhere in the SoC
//   ResetSeqState : reset sequencer FSM states
//   CAUSE_*       : reset_cause encodings
//   cnt_width()   : width of counters that must reach the largest stage length
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    SimIdle = 2'd0,
    SimRun  = 2'd1,
    SimHalt = 2'd2
  } SimState;

  typedef enum logic [1:0] {
    RSHold          = 2'd0,
    RSReleasePeriph = 2'd1,
    RSRun           = 2'd2
  } ResetSeqState;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SW     = 2'b10;
  localparam logic [1:0] CAUSE_UNUSED = 2'b11;

  // One spare bit above the largest terminal count so counters can never wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Button / software request inputs and staged reset outputs of the sequencer.
//   master : drives button_n, sw_reset_req; observes resets, ready, cause
//   slave  : the sequencer side
interface reset_sequencer_if;
  logic       button_n;
  logic       sw_reset_req;
  logic       rst_periph;
  logic       rst_cpu;
  logic       ready;
  logic [1:0] reset_cause;

  modport master (
    output button_n, sw_reset_req,
    input  rst_periph, rst_cpu, ready, reset_cause
  );

  modport slave (
    input  button_n, sw_reset_req,
    output rst_periph, rst_cpu, ready, reset_cause
  );
endinterface

// File: rtl/button_debouncer.sv
// 2-flop synchronizer plus debounce counter for an active-low push button.
//   clk_48mhz : clock
//   reset     : synchronous active-high reset (synchronizer preloads released)
//   button_n  : asynchronous raw button, low = pressed
//   pressed   : debounced pressed flag
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CW              = 4
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic button_n,
  output logic pressed
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          differs;

  // Synchronized level is low while pressed, so equality with the flag
  // means the input disagrees with the accepted state.
  assign differs = (sync_q[1] == pressed_q);

  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (differs) begin
      if (cnt_q == DEB_LAST) begin
        pressed_d = ~pressed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], button_n};
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds everything in reset, releases peripherals,
// then the CPU after a gap. Re-enters the hold on a debounced button press or
// a software request while running.
//   clk_48mhz : clock
//   reset     : synchronous active-high hard reset
//   bus       : button_n, sw_reset_req in; rst_periph, rst_cpu, ready,
//               reset_cause out
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int POR_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STAGE_GAP       = 4
) (
  input  logic                clk_48mhz,
  input  logic                reset,
  reset_sequencer_if.slave    bus
);

  localparam int CW = cnt_width(POR_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);

  ResetSeqState  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          pressed, pressed_prev_q;
  logic          press_evt;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CW              (CW)
  ) u_deb (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .button_n  (bus.button_n),
    .pressed   (pressed)
  );

  assign press_evt = pressed & ~pressed_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      RSHold: begin
        if (press_evt) cause_d = CAUSE_BUTTON;
        // Hold time is measured from button release, not from entry.
        if (pressed) begin
          cnt_d = '0;
        end else if (cnt_q == POR_LAST) begin
          state_d = RSReleasePeriph;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RSReleasePeriph: begin
        if (press_evt) begin
          state_d = RSHold;
          cnt_d   = '0;
          cause_d = CAUSE_BUTTON;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RSRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RSRun: begin
        cnt_d = '0;
        // Button takes priority when both requests land together.
        if (press_evt) begin
          state_d = RSHold;
          cause_d = CAUSE_BUTTON;
        end else if (bus.sw_reset_req) begin
          state_d = RSHold;
          cause_d = CAUSE_SW;
        end
      end
      default: begin
        state_d = RSHold;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q        <= RSHold;
      cnt_q          <= '0;
      cause_q        <= CAUSE_POR;
      pressed_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      pressed_prev_q <= pressed;
    end
  end

  assign bus.rst_periph  = (state_q == RSHold);
  assign bus.rst_cpu     = (state_q != RSRun);
  assign bus.ready       = (state_q == RSRun);
  assign bus.reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam int POR = 16;
  localparam int DEB = 8;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reset_sequencer_if bus();

  reset_sequencer #(
    .POR_CYCLES      (POR),
    .DEBOUNCE_CYCLES (DEB),
    .STAGE_GAP       (GAP)
  ) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 hold, 1 peripherals released, 2 running.
  // Stage length tracked as cycles remaining; debounce as a sliding window
  // of the last DEB synchronized samples; synchronizer as a 2-deep queue.
  int         m_phase;
  int         m_left;
  logic [1:0] m_cause;
  bit         m_pressed, m_prev, m_evt, m_all;
  bit         m_raw[$];
  bit         m_hist[$];

  wire [4:0] act = {bus.rst_periph, bus.rst_cpu, bus.ready, bus.reset_cause};

  function automatic logic [4:0] exp_out();
    return {m_phase == 0, m_phase != 2, m_phase == 2, m_cause};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_left = POR; m_cause = 2'b00;
      m_pressed = 0; m_prev = 0;
      m_raw = '{1'b1, 1'b1};
      m_hist.delete();
    end else begin
      m_evt = m_pressed && !m_prev;
      case (m_phase)
        0: begin
          if (m_evt) m_cause = 2'b01;
          if (m_pressed) m_left = POR;
          else begin
            m_left--;
            if (m_left == 0) begin m_phase = 1; m_left = GAP; end
          end
        end
        1: begin
          if (m_evt) begin m_phase = 0; m_left = POR; m_cause = 2'b01; end
          else begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
        default: begin
          if (m_evt) begin m_phase = 0; m_left = POR; m_cause = 2'b01; end
          else if (bus.sw_reset_req) begin m_phase = 0; m_left = POR; m_cause = 2'b10; end
        end
      endcase
      m_prev = m_pressed;
      m_hist.push_back(m_raw[0]);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
        m_all = 1;
        foreach (m_hist[j]) if (m_hist[j] != m_pressed) m_all = 0;
        if (m_all) m_pressed = !m_pressed;
      end
      m_raw.push_back(bus.button_n);
      void'(m_raw.pop_front());
    end
  end

  task automatic cyc(input bit b, input bit sw);
    bus.button_n = b;
    bus.sw_reset_req = sw;
    @(negedge clk);
  endtask

  task automatic wait_run();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 300) begin cyc(1, 0); n++; end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL wait_run timeout ready=%b required 1", bus.ready);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      checks++;
      if (act !== 5'b11000) begin errors++; $display("FAIL reset_hold got %b required %b", act, 5'b11000); end
    end
    reset = 0;
    n = 0;
    while (bus.rst_periph === 1'b1 && n < 100) begin
      cyc(1, 0); n++;
      checks++;
      if (act !== exp_out()) begin errors++; $display("FAIL por_model got %b required %b", act, exp_out()); end
    end
    checks++;
    if (n !== POR) begin errors++; $display("FAIL por_periph_delay got %0d required %0d", n, POR); end
    n = 0;
    while (bus.rst_cpu === 1'b1 && n < 100) begin
      cyc(1, 0); n++;
      checks++;
      if (act !== exp_out()) begin errors++; $display("FAIL por_gap_model got %b required %b", act, exp_out()); end
    end
    checks++;
    if (n !== GAP) begin errors++; $display("FAIL por_cpu_gap got %0d required %0d", n, GAP); end
    checks++;
    if (act !== 5'b00100) begin errors++; $display("FAIL por_run got %b required %b", act, 5'b00100); end
  endtask

  task automatic test_short_press();
    for (int i = 0; i < 25; i++) begin
      cyc(i < 5 ? 1'b0 : 1'b1, 0);
      checks++;
      if (act !== 5'b00100) begin errors++; $display("FAIL short_press got %b required %b", act, 5'b00100); end
    end
  endtask

  task automatic test_long_press();
    int n = 0;
    while (bus.rst_periph !== 1'b1 && n < 100) begin
      cyc(0, 0); n++;
      checks++;
      if (act !== exp_out()) begin errors++; $display("FAIL long_model got %b required %b", act, exp_out()); end
    end
    checks++;
    if (n !== 2 + DEB + 1) begin errors++; $display("FAIL long_assert_delay got %0d required %0d", n, 2 + DEB + 1); end
    for (int i = n; i < 40; i++) begin
      cyc(0, 0);
      checks++;
      if (act[4:3] !== 2'b11) begin errors++; $display("FAIL long_held got %b required 11", act[4:3]); end
    end
    n = 0;
    while (bus.rst_periph === 1'b1 && n < 200) begin cyc(1, 0); n++; end
    checks++;
    if (n !== 2 + DEB + POR) begin errors++; $display("FAIL long_release_delay got %0d required %0d", n, 2 + DEB + POR); end
    checks++;
    if (bus.reset_cause !== 2'b01) begin errors++; $display("FAIL long_cause got %b required 01", bus.reset_cause); end
    wait_run();
  endtask

  task automatic test_sw();
    int n = 0;
    cyc(1, 1);
    checks++;
    if (act !== 5'b11010) begin errors++; $display("FAIL sw_assert got %b required %b", act, 5'b11010); end
    while (bus.rst_periph === 1'b1 && n < 100) begin cyc(1, 0); n++; end
    checks++;
    if (n !== POR) begin errors++; $display("FAIL sw_hold_len got %0d required %0d", n, POR); end
    n = 0;
    while (bus.rst_cpu === 1'b1 && n < 100) begin cyc(1, 0); n++; end
    checks++;
    if (n !== GAP) begin errors++; $display("FAIL sw_gap_len got %0d required %0d", n, GAP); end
    checks++;
    if (act !== 5'b00110) begin errors++; $display("FAIL sw_run got %b required %b", act, 5'b00110); end
  endtask

  task automatic test_same_cycle();
    int n = 0;
    for (int i = 0; i < 2 + DEB; i++) cyc(0, 0);
    cyc(0, 1);
    checks++;
    if (act !== 5'b11001) begin errors++; $display("FAIL same_cycle_cause got %b required %b", act, 5'b11001); end
    while (bus.rst_periph === 1'b1 && n < 200) begin cyc(1, 0); n++; end
    cyc(1, 1);
    checks++;
    if (act !== 5'b01001) begin errors++; $display("FAIL sw_in_release got %b required %b", act, 5'b01001); end
    n = 1;
    while (bus.ready !== 1'b1 && n < 100) begin cyc(1, 0); n++; end
    checks++;
    if (n !== GAP) begin errors++; $display("FAIL release_len_after_sw got %0d required %0d", n, GAP); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    cyc(1, 1);
    while (bus.rst_periph === 1'b1 && n < 100) begin cyc(1, 0); n++; end
    cyc(1, 0);
    checks++;
    if (act !== 5'b01010) begin errors++; $display("FAIL mid_pre got %b required %b", act, 5'b01010); end
    reset = 1;
    cyc(1, 0);
    reset = 0;
    checks++;
    if (act !== 5'b11000) begin errors++; $display("FAIL mid_reset got %b required %b", act, 5'b11000); end
    n = 0;
    while (bus.rst_periph === 1'b1 && n < 100) begin cyc(1, 0); n++; end
    checks++;
    if (n !== POR) begin errors++; $display("FAIL mid_hold_len got %0d required %0d", n, POR); end
    wait_run();
  endtask

  task automatic test_random();
    int seg = 0;
    bit lvl = 1;
    bit sw;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lvl = !lvl;
        seg = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 20));
      end
      seg--;
      sw = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc(lvl, sw);
      checks++;
      if (act !== exp_out()) begin
        errors++; $display("FAIL random_model cycle %0d got %b required %b", i, act, exp_out());
      end
    end
    reset = 0;
  endtask

  initial begin
    bus.button_n = 1'b1;
    bus.sw_reset_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_short_press();
    test_long_press();
    test_sw();
    test_same_cycle();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
